i2s_tdm_receiver: RTL and testbench

I2S_TDM_RECEIVER -- requirements
Module: i2s_tdm_receiver

---
 rtl/i2s_rx_pkg.sv | 22 ++
 rtl/i2s_rx_sync.sv | 46 ++++
 rtl/i2s_tdm_receiver.sv | 150 +++++++++++++++
 tb/tb_i2s_tdm_receiver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared types and helpers for the I2S/TDM receiver.
// Related build macro: I2S_TDM_RECEIVER_ERROR_COUNT_EN (used by the top level).
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSkip,
    StRecv
  } rx_state_e;

  // DATA_DELAY modes: bit clocks skipped after the frame-start qualifier rises
  localparam int unsigned MODE_MSB_JUSTIFIED = 0;
  localparam int unsigned MODE_I2S           = 1;

  // Bit-address width of the circular frame buffer
  function automatic int unsigned rx_addr_width(input int unsigned channels,
                                                input int unsigned slot_bits,
                                                input int unsigned circ_buf_bits);
    return circ_buf_bits + $clog2(channels * slot_bits);
  endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Synchronises the serial-port inputs into clk_i and detects their edges.
// Data travels through the same number of stages as BCLK, so data_o is the
// level that was present when the detected BCLK edge happened.
module i2s_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bclk_i,
  input  logic data_i,
  input  logic running_i,
  output logic bclk_rise_o,
  output logic data_o,
  output logic running_o,
  output logic running_rise_o,
  output logic running_fall_o
);

  logic [1:0] bclk_sync_q;
  logic [1:0] data_sync_q;
  logic [1:0] running_sync_q;
  logic       bclk_prev_q;
  logic       running_prev_q;

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bclk_sync_q    <= '0;
      data_sync_q    <= '0;
      running_sync_q <= '0;
      bclk_prev_q    <= 1'b0;
      running_prev_q <= 1'b0;
    end else begin
      bclk_sync_q    <= {bclk_sync_q[0], bclk_i};
      data_sync_q    <= {data_sync_q[0], data_i};
      running_sync_q <= {running_sync_q[0], running_i};
      bclk_prev_q    <= bclk_sync_q[1];
      running_prev_q <= running_sync_q[1];
    end
  end

  assign bclk_rise_o    = bclk_sync_q[1] & ~bclk_prev_q;
  assign data_o         = data_sync_q[1];
  assign running_o      = running_sync_q[1];
  assign running_rise_o = running_sync_q[1] & ~running_prev_q;
  assign running_fall_o = ~running_sync_q[1] & running_prev_q;

endmodule

// File: rtl/i2s_tdm_receiver.sv
// I2S/TDM serial receiver writing one bit per BCLK into a circular frame RAM.
// Frames are packed back-to-back at frame_idx*FRAME_BITS, which is the same as
// {frame_idx, bit_cnt} whenever FRAME_BITS is a power of two.
// Optional build macro: I2S_TDM_RECEIVER_ERROR_COUNT_EN adds error_count_o.
module i2s_tdm_receiver
  import i2s_rx_pkg::*;
#(
  parameter int unsigned  CHANNELS      = 8,
  parameter int unsigned  SLOT_BITS     = 32,
  parameter int unsigned  CIRC_BUF_BITS = 3,
  parameter int unsigned  DATA_DELAY    = MODE_MSB_JUSTIFIED,
  localparam int unsigned FRAME_BITS    = CHANNELS * SLOT_BITS,
  localparam int unsigned ADDR_W        = rx_addr_width(CHANNELS, SLOT_BITS, CIRC_BUF_BITS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i2s_running_i,
  input  logic                     i2s_bclk_i,
  input  logic                     i2s_data_i,
  output logic [ADDR_W-1:0]        ram_write_addr_o,
  output logic                     ram_write_en_o,
  output logic                     ram_write_data_o,
  output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
  output logic                     frame_done_o,
  output logic                     frame_error_o
`ifdef I2S_TDM_RECEIVER_ERROR_COUNT_EN
  ,
  output logic [15:0]              error_count_o
`endif
);

  localparam int unsigned CNT_W  = $clog2(FRAME_BITS);
  localparam int unsigned SKIP_W = (DATA_DELAY > 1) ? $clog2(DATA_DELAY) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);
  localparam logic [SKIP_W-1:0] LAST_SKIP = SKIP_W'((DATA_DELAY > 0) ? DATA_DELAY - 1 : 0);

  logic bclk_rise;
  logic data_s;
  logic running_s;
  logic running_rise;
  logic running_fall;

  i2s_rx_sync u_sync (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .bclk_i         (i2s_bclk_i),
    .data_i         (i2s_data_i),
    .running_i      (i2s_running_i),
    .bclk_rise_o    (bclk_rise),
    .data_o         (data_s),
    .running_o      (running_s),
    .running_rise_o (running_rise),
    .running_fall_o (running_fall)
  );

  rx_state_e                state_q;
  logic [CIRC_BUF_BITS-1:0] frame_idx_q;
  logic [CNT_W-1:0]         bit_cnt_q;
  logic [SKIP_W-1:0]        skip_cnt_q;
  logic [ADDR_W-1:0]        frame_base;

  // Start address of the frame slot currently being filled
  always_comb begin
    frame_base = ADDR_W'(frame_idx_q) * ADDR_W'(FRAME_BITS);
  end

  // Receive FSM with registered RAM-write and status outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q               <= StIdle;
      frame_idx_q           <= '0;
      bit_cnt_q             <= '0;
      skip_cnt_q            <= '0;
      ram_write_addr_o      <= '0;
      ram_write_en_o        <= 1'b0;
      ram_write_data_o      <= 1'b0;
      last_good_frame_idx_o <= '0;
      frame_done_o          <= 1'b0;
      frame_error_o         <= 1'b0;
    end else begin
      ram_write_en_o <= 1'b0;
      frame_done_o   <= 1'b0;
      frame_error_o  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ram_write_addr_o <= frame_base;
          bit_cnt_q        <= '0;
          skip_cnt_q       <= '0;
          if (running_rise) begin
            state_q <= (DATA_DELAY == MODE_MSB_JUSTIFIED) ? StRecv : StSkip;
          end
        end
        StSkip: begin
          if (bclk_rise) begin
            skip_cnt_q <= skip_cnt_q + SKIP_W'(1);
            if (skip_cnt_q == LAST_SKIP) begin
              state_q <= StRecv;
            end
          end
          // Nothing captured yet, so a drop here is not a partial frame
          if (running_fall) begin
            state_q <= StIdle;
          end
        end
        StRecv: begin
          if (bclk_rise) begin
            ram_write_en_o   <= 1'b1;
            ram_write_data_o <= data_s;
            ram_write_addr_o <= frame_base + ADDR_W'(bit_cnt_q);
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q             <= '0;
              frame_idx_q           <= frame_idx_q + CIRC_BUF_BITS'(1);
              last_good_frame_idx_o <= frame_idx_q;
              frame_done_o          <= 1'b1;
              // Back-to-back frames continue without a new skip phase
              if (!running_s) begin
                state_q <= StIdle;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              // The edge is stored first; the frame is then partial, so abort
              if (running_fall) begin
                frame_error_o <= 1'b1;
                bit_cnt_q     <= '0;
                state_q       <= StIdle;
              end
            end
          end else if (running_fall) begin
            frame_error_o <= (bit_cnt_q != '0);
            bit_cnt_q     <= '0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef I2S_TDM_RECEIVER_ERROR_COUNT_EN
  // Saturating count of aborted frames
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      error_count_o <= '0;
    end else if (frame_error_o && (error_count_o != 16'hFFFF)) begin
      error_count_o <= error_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tdm_receiver.sv
// Scoreboard bench for i2s_tdm_receiver: one default instance and one
// 2x24-bit, 4-frame, I2S-delay instance, each with its own serial port.
`timescale 1ns/1ps
module tb_i2s_tdm_receiver;

  localparam int HALF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst[2];
  logic running[2];
  logic bclk[2];
  logic sdata[2];

  logic [10:0] addr0;
  logic        en0, d0, done0, err0;
  logic [2:0]  lg0;
  logic [7:0]  addr1;
  logic        en1, d1, done1, err1;
  logic [1:0]  lg1;
`ifdef I2S_TDM_RECEIVER_ERROR_COUNT_EN
  logic [15:0] ec0, ec1;
`endif

  i2s_tdm_receiver dut0 (
    .clk_i                 (clk),
    .rst_i                 (rst[0]),
    .i2s_running_i         (running[0]),
    .i2s_bclk_i            (bclk[0]),
    .i2s_data_i            (sdata[0]),
    .ram_write_addr_o      (addr0),
    .ram_write_en_o        (en0),
    .ram_write_data_o      (d0),
    .last_good_frame_idx_o (lg0),
    .frame_done_o          (done0),
    .frame_error_o         (err0)
`ifdef I2S_TDM_RECEIVER_ERROR_COUNT_EN
    ,
    .error_count_o         (ec0)
`endif
  );

  i2s_tdm_receiver #(
    .CHANNELS      (2),
    .SLOT_BITS     (24),
    .CIRC_BUF_BITS (2),
    .DATA_DELAY    (1)
  ) dut1 (
    .clk_i                 (clk),
    .rst_i                 (rst[1]),
    .i2s_running_i         (running[1]),
    .i2s_bclk_i            (bclk[1]),
    .i2s_data_i            (sdata[1]),
    .ram_write_addr_o      (addr1),
    .ram_write_en_o        (en1),
    .ram_write_data_o      (d1),
    .last_good_frame_idx_o (lg1),
    .frame_done_o          (done1),
    .frame_error_o         (err1)
`ifdef I2S_TDM_RECEIVER_ERROR_COUNT_EN
    ,
    .error_count_o         (ec1)
`endif
  );

  // Expected event queues: writes as (addr<<1)|bit, done/error as last-good index
  int wq[2][$];
  int dq[2][$];
  int eq[2][$];

  // Reference model state per instance
  int  fb[2]  = '{256, 48};
  int  nf[2]  = '{8, 4};
  int  dly[2] = '{0, 1};
  int  fidx[2], bc[2], skip[2], lg[2], nerr[2];
  bit  active[2];

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(input int i, input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL inst%0d %s: got %0d, expected %0d", i, name, act, exp);
    end
  endfunction

  function automatic void unexpected(input int i, input string name, input int act);
    n_checks++;
    n_errors++;
    $display("FAIL inst%0d %s: got event with value %0d, expected no event", i, name, act);
  endfunction

  task automatic mon(input int i, input logic en, input int addr, input logic d,
                     input logic done, input logic err, input int lgv);
    int e;
    if (en) begin
      if (wq[i].size() == 0) unexpected(i, "write", addr);
      else begin
        e = wq[i].pop_front();
        check(i, "write_addr", addr, e >> 1);
        check(i, "write_data", int'(d), e & 1);
      end
    end
    if (done) begin
      if (dq[i].size() == 0) unexpected(i, "frame_done", lgv);
      else begin
        e = dq[i].pop_front();
        check(i, "done_last_good", lgv, e);
      end
    end
    if (err) begin
      if (eq[i].size() == 0) unexpected(i, "frame_error", lgv);
      else begin
        e = eq[i].pop_front();
        check(i, "error_last_good", lgv, e);
      end
    end
  endtask

  always @(negedge clk) mon(0, en0, int'(addr0), d0, done0, err0, int'(lg0));
  always @(negedge clk) mon(1, en1, int'(addr1), d1, done1, err1, int'(lg1));

  task automatic model_reset(input int i);
    wq[i].delete();
    dq[i].delete();
    eq[i].delete();
    fidx[i]   = 0;
    bc[i]     = 0;
    skip[i]   = 0;
    lg[i]     = 0;
    nerr[i]   = 0;
    active[i] = 1'b0;
  endtask

  task automatic model_bit(input int i, input bit d);
    if (!active[i]) return;
    if (skip[i] > 0) begin
      skip[i]--;
      return;
    end
    wq[i].push_back(((fidx[i] * fb[i] + bc[i]) << 1) | int'(d));
    bc[i]++;
    if (bc[i] == fb[i]) begin
      dq[i].push_back(fidx[i]);
      lg[i]   = fidx[i];
      fidx[i] = (fidx[i] + 1) % nf[i];
      bc[i]   = 0;
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int i, input bit d);
    sdata[i] = d;
    waitc(HALF);
    bclk[i] = 1'b1;
    model_bit(i, d);
    waitc(HALF);
    bclk[i] = 1'b0;
  endtask

  task automatic set_running(input int i, input bit v);
    running[i] = v;
    if (v) begin
      active[i] = 1'b1;
      skip[i]   = dly[i];
      bc[i]     = 0;
    end else begin
      if (active[i] && bc[i] != 0) begin
        eq[i].push_back(lg[i]);
        nerr[i]++;
      end
      active[i] = 1'b0;
      bc[i]     = 0;
    end
    waitc(2 * HALF);
  endtask

  task automatic drain(input int i);
    int k = 0;
    while ((wq[i].size() + dq[i].size() + eq[i].size()) != 0 && k < 200) begin
      waitc(1);
      k++;
    end
    check(i, "pending_events_after_drain", wq[i].size() + dq[i].size() + eq[i].size(), 0);
  endtask

  // Running high, nbits random bits, then running dropped
  task automatic run(input int i, input int nbits);
    set_running(i, 1'b1);
    for (int b = 0; b < nbits; b++) send_bit(i, 1'($urandom_range(0, 1)));
    waitc(2 * HALF);
    set_running(i, 1'b0);
    drain(i);
  endtask

  task automatic chk_zero(input int i);
    if (i == 0) begin
      check(0, "rst_addr", int'(addr0), 0);
      check(0, "rst_en", int'(en0), 0);
      check(0, "rst_data", int'(d0), 0);
      check(0, "rst_last_good", int'(lg0), 0);
      check(0, "rst_done", int'(done0), 0);
      check(0, "rst_error", int'(err0), 0);
    end else begin
      check(1, "rst_addr", int'(addr1), 0);
      check(1, "rst_en", int'(en1), 0);
      check(1, "rst_data", int'(d1), 0);
      check(1, "rst_last_good", int'(lg1), 0);
      check(1, "rst_done", int'(done1), 0);
      check(1, "rst_error", int'(err1), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    for (int i = 0; i < 2; i++) begin
      rst[i]     = 1'b1;
      running[i] = 1'b0;
      bclk[i]    = 1'b0;
      sdata[i]   = 1'b0;
      model_reset(i);
    end
    waitc(4);
    chk_zero(0);
    chk_zero(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    waitc(4);

    // Eight full frames back-to-back, then 40 bits into the wrapped slot 0
    run(0, 8 * 256 + 40);
    // Frames 0 and 1, then abort 100 bits into frame 2
    run(0, 2 * 256 + 100);
    // Frame 2 rewritten from its own base; drop at a frame boundary is clean
    run(0, 256);
    waitc(4);
    check(0, "idle_addr", int'(addr0), 3 * 256);
    check(0, "idle_en", int'(en0), 0);

    // Reset 37 bits into a frame: partial frame silently discarded
    set_running(0, 1'b1);
    for (int b = 0; b < 37; b++) send_bit(0, 1'($urandom_range(0, 1)));
    waitc(2 * HALF);
    drain(0);
    rst[0] = 1'b1;
    #1;
    chk_zero(0);
    model_reset(0);
    running[0] = 1'b0;
    waitc(3);
    rst[0] = 1'b0;
    waitc(3);
    // Reception restarts at address 0; three aborted frames follow
    run(0, 20);
    run(0, 10);
    run(0, 15);
`ifdef I2S_TDM_RECEIVER_ERROR_COUNT_EN
    waitc(2);
    check(0, "error_count", int'(ec0), nerr[0]);
`endif

    // I2S delay: leading 1 is skipped, then 0xA5, then enough bits to wrap
    set_running(1, 1'b1);
    send_bit(1, 1'b1);
    pat = 8'hA5;
    for (int b = 7; b >= 0; b--) send_bit(1, pat[b]);
    for (int b = 0; b < 4 * 48 + 10 - 8; b++) send_bit(1, 1'($urandom_range(0, 1)));
    waitc(2 * HALF);
    set_running(1, 1'b0);
    drain(1);
`ifdef I2S_TDM_RECEIVER_ERROR_COUNT_EN
    waitc(2);
    check(1, "error_count", int'(ec1), nerr[1]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
